// File: rtl/controller_pkg.sv
// Shared types and constants for the standby-mode I2C bus monitor.
//   i2c_mon_state_e : bus monitor FSM state encoding
//   I2cByteBits     : data bits per I2C byte (ACK bit excluded)
package controller_pkg;

  localparam int unsigned I2cByteBits = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_SKIP
  } i2c_mon_state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Per-line glitch filter for a synchronized I2C line.
// The filtered level only follows the input after FilterCycles consecutive
// samples that differ from the current filtered level.
// Ports:
//   clk_i   : system clock
//   rst_ni  : asynchronous active-low reset (filtered level resets to 1)
//   line_i  : synchronized raw line level
//   line_o  : filtered line level
module i2c_line_filter #(
  parameter int unsigned FilterCycles = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic line_i,
  output logic line_o
);

  logic [3:0] cnt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      line_o <= 1'b1;
    end else if (line_i == line_o) begin
      cnt_q <= '0;
    end else if (cnt_q == 4'(FilterCycles - 1)) begin
      cnt_q  <= '0;
      line_o <= line_i;
    end else begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/i2c_standby_bus_monitor.sv
// Passive I2C bus observer for the standby-mode I2C target. Never drives
// the bus; reports START / repeated START / STOP, the first byte after each
// START/Sr, bus busy level, and host NACK on read data.
// Optional feature: define I2C_BUS_MON_FILTER_EN to insert a per-line
// glitch filter (FilterCycles samples) ahead of the sample registers.
// Ports:
//   clk_i, rst_ni    : clock, asynchronous active-low reset
//   enable_i         : monitor enable
//   scl_i, sda_i     : synchronized bus levels
//   bus_start_o      : pulse, START while bus idle
//   bus_rstart_o     : pulse, START while bus busy
//   bus_stop_o       : pulse, STOP
//   bus_busy_o       : level, START..STOP
//   bus_addr_o       : {addr[6:0], RnW} of the latest address byte
//   bus_addr_valid_o : pulse when bus_addr_o updates
//   tx_host_nack_o   : pulse, host NACKed a read data byte
module i2c_standby_bus_monitor
  import controller_pkg::*;
#(
  parameter int unsigned FilterCycles = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       enable_i,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       bus_start_o,
  output logic       bus_rstart_o,
  output logic       bus_stop_o,
  output logic       bus_busy_o,
  output logic [7:0] bus_addr_o,
  output logic       bus_addr_valid_o,
  output logic       tx_host_nack_o
);

  if (FilterCycles < 1 || FilterCycles > 15) begin : g_bad_filter_cfg
    $error("FilterCycles must be within 1..15");
  end

  logic scl_lvl, sda_lvl;

`ifdef I2C_BUS_MON_FILTER_EN
  i2c_line_filter #(.FilterCycles(FilterCycles)) u_scl_filter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .line_i (scl_i),
    .line_o (scl_lvl)
  );
  i2c_line_filter #(.FilterCycles(FilterCycles)) u_sda_filter (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .line_i (sda_i),
    .line_o (sda_lvl)
  );
`else
  assign scl_lvl = scl_i;
  assign sda_lvl = sda_i;
`endif

  logic           scl_q, sda_q, scl_prev, sda_prev;
  i2c_mon_state_e state_q, state_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d, bit_inc;
  logic [7:0]     shift_q, shift_d, addr_d;
  logic           rnw_q, rnw_d, busy_d;
  logic           start_d, rstart_d, stop_d, valid_d, nack_d;
  logic           start_det, stop_det, scl_rise;

  // Bus conditions require SCL high in both samples, so a simultaneous
  // SCL/SDA change is treated as an ordinary data change.
  assign start_det = scl_prev & scl_q &  sda_prev & ~sda_q;
  assign stop_det  = scl_prev & scl_q & ~sda_prev &  sda_q;
  assign scl_rise  = ~scl_prev & scl_q;
  assign bit_inc   = (bit_cnt_q == 4'(I2cByteBits)) ? bit_cnt_q : bit_cnt_q + 4'd1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      scl_q            <= 1'b1;
      sda_q            <= 1'b1;
      scl_prev         <= 1'b1;
      sda_prev         <= 1'b1;
      state_q          <= ST_IDLE;
      bit_cnt_q        <= '0;
      shift_q          <= '0;
      rnw_q            <= 1'b0;
      bus_busy_o       <= 1'b0;
      bus_addr_o       <= '0;
      bus_start_o      <= 1'b0;
      bus_rstart_o     <= 1'b0;
      bus_stop_o       <= 1'b0;
      bus_addr_valid_o <= 1'b0;
      tx_host_nack_o   <= 1'b0;
    end else begin
      scl_q            <= scl_lvl;
      sda_q            <= sda_lvl;
      scl_prev         <= scl_q;
      sda_prev         <= sda_q;
      state_q          <= state_d;
      bit_cnt_q        <= bit_cnt_d;
      shift_q          <= shift_d;
      rnw_q            <= rnw_d;
      bus_busy_o       <= busy_d;
      bus_addr_o       <= addr_d;
      bus_start_o      <= start_d;
      bus_rstart_o     <= rstart_d;
      bus_stop_o       <= stop_d;
      bus_addr_valid_o <= valid_d;
      tx_host_nack_o   <= nack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    rnw_d     = rnw_q;
    busy_d    = bus_busy_o;
    addr_d    = bus_addr_o;
    start_d   = 1'b0;
    rstart_d  = 1'b0;
    stop_d    = 1'b0;
    valid_d   = 1'b0;
    nack_d    = 1'b0;

    if (!enable_i) begin
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
      busy_d    = 1'b0;
    end else if (start_det) begin
      start_d   = ~bus_busy_o;
      rstart_d  = bus_busy_o;
      busy_d    = 1'b1;
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
    end else if (stop_det) begin
      stop_d    = 1'b1;
      busy_d    = 1'b0;
      state_d   = ST_IDLE;
      bit_cnt_d = '0;
    end else if (scl_rise) begin
      unique case (state_q)
        ST_ADDR: begin
          shift_d = {shift_q[6:0], sda_q};
          if (bit_inc == 4'(I2cByteBits)) begin
            addr_d    = shift_d;
            valid_d   = 1'b1;
            rnw_d     = sda_q;
            bit_cnt_d = '0;
            state_d   = ST_ADDR_ACK;
          end else begin
            bit_cnt_d = bit_inc;
          end
        end
        ST_ADDR_ACK: state_d = sda_q ? ST_SKIP : ST_DATA;
        ST_DATA: begin
          if (bit_inc == 4'(I2cByteBits)) begin
            bit_cnt_d = '0;
            state_d   = ST_DATA_ACK;
          end else begin
            bit_cnt_d = bit_inc;
          end
        end
        ST_DATA_ACK: begin
          if (rnw_q && sda_q) begin
            nack_d  = 1'b1;
            state_d = ST_SKIP;
          end else begin
            state_d = ST_DATA;
          end
        end
        default: ; // IDLE and SKIP ignore SCL activity
      endcase
    end
  end

endmodule

// File: doc/i2c_standby_bus_monitor.md
Name: i2c_standby_bus_monitor

Overview:
- Passive I2C bus observer running beside the standby-mode I2C target FSM, on the same synchronized SCL/SDA.
- Produces the bus-event signals the standby I2C controller currently ties to zero: START, repeated START, STOP, received address byte with RnW, host NACK on read data.
- Consumed by the recovery handler and the TTI status logic.
- Never drives the bus.

Parameters:
- FilterCycles, 2, consecutive identical samples needed before a filtered SCL/SDA level changes. Only used with the filter feature; range 1..15.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  reset, asynchronous, active-low
- enable_i  input  1  monitor enable (i2c_standby_en)
- scl_i  input  1  synchronized SCL level
- sda_i  input  1  synchronized SDA level
- bus_start_o  output  1  1-cycle pulse: START seen while bus idle
- bus_rstart_o  output  1  1-cycle pulse: START seen while bus busy
- bus_stop_o  output  1  1-cycle pulse: STOP seen
- bus_busy_o  output  1  level: high from START until STOP
- bus_addr_o  output  8  first byte after START/Sr ({addr[6:0], RnW}); held until next START/Sr
- bus_addr_valid_o  output  1  1-cycle pulse when bus_addr_o is updated
- tx_host_nack_o  output  1  1-cycle pulse: host NACKed a read data byte

Behaviour:
- Reset: all outputs 0; FSM IDLE; bit counter 0; scl_q/sda_q sample registers 1.
- Sampling: scl_q/sda_q register the filtered (or raw) levels each cycle. Edges are found by comparing each level with its previous sample.
- START: sda_q 1->0 while SCL high in both the previous and current sample.
- STOP: sda_q 0->1 under the same SCL condition.
- If SCL and SDA change in the same sample, treat it as a data change, not a bus condition.
- Output timing: condition and valid outputs are registered. A pulse asserts in the cycle after the edge is detected, i.e. 2 clk cycles after the first clock that samples the new level (no filter).
- Pulse routing: START while bus_busy_o=0 -> bus_start_o; START while bus_busy_o=1 -> bus_rstart_o.
- bus_busy_o: set on START, cleared on STOP.
- FSM states: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, SKIP.
  - Any START/Sr, in any state -> ADDR, bit counter cleared.
  - STOP, in any state -> IDLE.
- ADDR: sample sda_q on each SCL rising edge into an 8-bit shift register, MSB first.
  - On the 8th rise: load bus_addr_o, pulse bus_addr_valid_o, latch rnw = bit0, go to ADDR_ACK.
- ADDR_ACK: on the 9th rise, SDA=0 -> DATA; SDA=1 -> SKIP. The address NACK is not reported.
- DATA: count 8 SCL rises, then DATA_ACK.
- DATA_ACK: on the 9th rise:
  - rnw=1 and SDA=1: pulse tx_host_nack_o, go to SKIP.
  - otherwise: back to DATA.
- SKIP: ignore SCL until START/Sr/STOP.
- Bit counter: 4 bits, saturates at 8, cleared on byte completion.
- Unexpected activity: an SCL rising edge in IDLE is ignored (bus not owned).
- enable_i low: FSM forced to IDLE, bus_busy_o cleared, pulses suppressed, bus_addr_o retained. The sample registers keep running, so re-enable does not create false edges.
- Reset mid-transfer: immediate return to reset values. The monitor resynchronizes on the next START.

Optional Feature:
- Macro: I2C_BUS_MON_FILTER_EN.
- Defined: per-line glitch filter ahead of scl_q/sda_q. A 4-bit counter per line; the filtered level changes only after FilterCycles consecutive samples that differ from it. Latency grows by FilterCycles cycles.
- Undefined: no filter; raw inputs feed scl_q/sda_q; FilterCycles unused.

Decomposition:
- Into controller_pkg: the FSM state enum i2c_mon_state_e, and constant I2cByteBits = 8.
- One sub-module, i2c_line_filter, instantiated twice (SCL, SDA) only under the macro.
- The rest stays in i2c_standby_bus_monitor.

Test Plan:
- START, address 0x18 (0x0C write), target ACK, 2 data bytes, STOP -> bus_start_o 1 pulse; bus_addr_o=0x18 with 1 valid pulse; bus_busy_o high until bus_stop_o pulse; no tx_host_nack_o.
- START, 0x19 read, ACK, byte 0xA5 host ACK, byte 0x3C host NACK, STOP -> exactly 1 tx_host_nack_o, on the 9th rise of the second byte.
- START, 0x18 write, 1 byte, Sr, 0x19 read -> bus_rstart_o 1 pulse, no second bus_start_o; bus_addr_o 0x18 then 0x19; 2 valid pulses.
- Address 0x42 NACKed (SDA=1 on 9th rise), then 3 clocked bytes, STOP -> FSM in SKIP, no further valid/nack pulses, stop pulse seen.
- Filter on, FilterCycles=2: 1-cycle SDA low glitch while SCL high -> no bus_start_o; a 3-cycle low does produce it.
- enable_i dropped mid-byte, then raised -> bus_busy_o=0 immediately, no pulses until the next START; the next START gives bus_start_o (not rstart).
